// File: rtl/ctrl_pipeline_if.sv
// ctrl_pipeline_if: bundles the ID-stage instruction fields, the hazard and
// flush handshake, and the per-stage control outputs of ctrl_pipeline.
//   master : instruction source / datapath side (drives ID fields, branch_taken)
//   slave  : ctrl_pipeline (drives stall enables and stage controls)
// The illegal signal exists only when CTRL_ILLEGAL_TRAP_EN is defined.
interface ctrl_pipeline_if #(
    parameter int ALUOP_W = 4,
    parameter int RADDR_W = 5
);
    logic               id_valid;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [RADDR_W-1:0] id_rd;
    logic [RADDR_W-1:0] id_rs1;
    logic [RADDR_W-1:0] id_rs2;
    logic               branch_taken;

    logic               pc_write;
    logic               ifid_write;
    logic               ex_alusrc;
    logic [ALUOP_W-1:0] ex_aluop;
    logic               mem_branch;
    logic               mem_memread;
    logic               mem_memwrite;
    logic               mem_regwrite;
    logic               wb_memtoreg;
    logic               wb_regwrite;
    logic [RADDR_W-1:0] ex_rd;
    logic [RADDR_W-1:0] mem_rd;
    logic [RADDR_W-1:0] wb_rd;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic               illegal;
`endif

    modport master (
`ifdef CTRL_ILLEGAL_TRAP_EN
        input  illegal,
`endif
        output id_valid, opcode, funct3, funct7, id_rd, id_rs1, id_rs2, branch_taken,
        input  pc_write, ifid_write, ex_alusrc, ex_aluop,
        input  mem_branch, mem_memread, mem_memwrite, mem_regwrite,
        input  wb_memtoreg, wb_regwrite, ex_rd, mem_rd, wb_rd
    );

    modport slave (
`ifdef CTRL_ILLEGAL_TRAP_EN
        output illegal,
`endif
        input  id_valid, opcode, funct3, funct7, id_rd, id_rs1, id_rs2, branch_taken,
        output pc_write, ifid_write, ex_alusrc, ex_aluop,
        output mem_branch, mem_memread, mem_memwrite, mem_regwrite,
        output wb_memtoreg, wb_regwrite, ex_rd, mem_rd, wb_rd
    );
endinterface

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: control path of a 5-stage in-order pipeline. Decodes the ID
// instruction, carries its controls through EX/MEM/WB, stalls on load-use
// hazards and flushes EX/MEM on a taken branch.
// Ports:
//   clk    - rising-edge clock
//   reset  - synchronous, active-high; clears all stage registers
//   bus    - ctrl_pipeline_if.slave: ID fields, branch_taken, pc_write,
//            ifid_write, ex_*/mem_*/wb_* controls and stage destinations
// Option: define CTRL_ILLEGAL_TRAP_EN to add the registered illegal output;
//         undefined instructions then enter EX as bubbles.
module ctrl_pipeline #(
    parameter int ALUOP_W = 4,
    parameter int RADDR_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    ctrl_pipeline_if.slave bus
);
    typedef enum logic [6:0] {
        OP_R = 7'b0110011,
        OP_I = 7'b0010011,
        OP_L = 7'b0000011,
        OP_S = 7'b0100011,
        OP_B = 7'b1100011
    } opcode_e;

    typedef struct packed {
        logic               alusrc;
        logic [ALUOP_W-1:0] aluop;
        logic               branch;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               regwrite;
        logic [RADDR_W-1:0] rd;
    } ex_t;

    typedef struct packed {
        logic               branch;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
        logic               regwrite;
        logic [RADDR_W-1:0] rd;
    } mem_t;

    typedef struct packed {
        logic               memtoreg;
        logic               regwrite;
        logic [RADDR_W-1:0] rd;
    } wb_t;

    ex_t        dec;
    ex_t        ex_d;
    ex_t        ex_q;
    mem_t       mem_q;
    wb_t        wb_q;
    logic [3:0] op4;
    logic       dec_ok;
    logic       hazard;
    logic       advance;
    logic       unused_funct7;

    // Only funct7[5] distinguishes add/sub; the other bits are don't-care.
    assign unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    always_comb begin
        dec    = '0;
        op4    = '0;
        dec_ok = 1'b1;
        case (bus.opcode)
            OP_R: begin
                dec.regwrite = 1'b1;
                case (bus.funct3)
                    3'b111:  op4 = 4'b0000;
                    3'b110:  op4 = 4'b0001;
                    3'b000:  op4 = bus.funct7[5] ? 4'b0110 : 4'b0010;
                    default: dec_ok = 1'b0;
                endcase
            end
            OP_I: begin
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                case (bus.funct3)
                    3'b000:  op4 = 4'b0010;
                    3'b001:  op4 = 4'b1100;
                    default: dec_ok = 1'b0;
                endcase
            end
            OP_L: begin
                dec.memread  = 1'b1;
                dec.memtoreg = 1'b1;
                dec.alusrc   = 1'b1;
                dec.regwrite = 1'b1;
                op4          = 4'b0010;
            end
            OP_S: begin
                dec.memwrite = 1'b1;
                dec.alusrc   = 1'b1;
                op4          = 4'b0010;
            end
            OP_B: begin
                dec.branch = 1'b1;
                op4        = 4'b0110;
            end
            default: dec_ok = 1'b0;
        endcase
        dec.aluop = ALUOP_W'(op4);
        dec.rd    = bus.id_rd;
        if (!dec_ok) begin
            dec = '0;
`ifndef CTRL_ILLEGAL_TRAP_EN
            // Without the trap, an undefined instruction still carries its rd.
            dec.rd = bus.id_rd;
`endif
        end
    end

    assign hazard = bus.id_valid && ex_q.memread && (ex_q.rd != '0) &&
                    ((ex_q.rd == bus.id_rs1) || (ex_q.rd == bus.id_rs2));

    // A taken branch overrides the stall: the stalled instruction is flushed anyway.
    assign bus.pc_write   = bus.branch_taken || !hazard;
    assign bus.ifid_write = bus.branch_taken || !hazard;

    assign advance = bus.id_valid && !bus.branch_taken && !hazard;

    always_comb begin
        ex_d = '0;
        if (advance) begin
            ex_d = dec;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic ill_q;
    always_ff @(posedge clk) begin
        if (reset) begin
            ill_q <= 1'b0;
        end else begin
            ill_q <= advance && !dec_ok;
        end
    end
    assign bus.illegal = ill_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q <= ex_d;
            if (bus.branch_taken) begin
                mem_q <= '0;
            end else begin
                mem_q.branch   <= ex_q.branch;
                mem_q.memread  <= ex_q.memread;
                mem_q.memwrite <= ex_q.memwrite;
                mem_q.memtoreg <= ex_q.memtoreg;
                mem_q.regwrite <= ex_q.regwrite;
                mem_q.rd       <= ex_q.rd;
            end
            wb_q.memtoreg <= mem_q.memtoreg;
            wb_q.regwrite <= mem_q.regwrite;
            wb_q.rd       <= mem_q.rd;
        end
    end

    assign bus.ex_alusrc    = ex_q.alusrc;
    assign bus.ex_aluop     = ex_q.aluop;
    assign bus.ex_rd        = ex_q.rd;
    assign bus.mem_branch   = mem_q.branch;
    assign bus.mem_memread  = mem_q.memread;
    assign bus.mem_memwrite = mem_q.memwrite;
    assign bus.mem_regwrite = mem_q.regwrite;
    assign bus.mem_rd       = mem_q.rd;
    assign bus.wb_memtoreg  = wb_q.memtoreg;
    assign bus.wb_regwrite  = wb_q.regwrite;
    assign bus.wb_rd        = wb_q.rd;
endmodule

// File: tb/tb_ctrl_pipeline.sv
`timescale 1ns/1ps
module tb_ctrl_pipeline;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    ctrl_pipeline_if #(.ALUOP_W(4), .RADDR_W(5)) bus ();
    ctrl_pipeline #(.ALUOP_W(4), .RADDR_W(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    int errors = 0;
    int checks = 0;

    localparam logic [6:0] R = 7'b0110011, I = 7'b0010011, L = 7'b0000011,
                           S = 7'b0100011, B = 7'b1100011;

    typedef struct packed {
        logic       alusrc;
        logic [3:0] aluop;
        logic       branch, memread, memwrite, memtoreg, regwrite;
        logic [4:0] rd;
        logic       ill;
    } ctl_t;

    ctl_t m_ex = '0, m_mem = '0, m_wb = '0;

    typedef struct {
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        bit         undef;
        logic       alusrc;
        logic [3:0] aluop;
        logic       branch, memread, memwrite, memtoreg, regwrite;
    } vec_t;

    localparam int NV = 13;
    vec_t vt [NV];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Decode table written straight from the instruction list.
    function automatic ctl_t ref_decode(input logic [6:0] op, input logic [2:0] f3,
                                        input logic [6:0] f7);
        ctl_t c;
        c = '0;
        case (op)
            R: begin
                c.regwrite = 1'b1;
                case (f3)
                    3'b111:  c.aluop = 4'd0;
                    3'b110:  c.aluop = 4'd1;
                    3'b000:  c.aluop = f7[5] ? 4'd6 : 4'd2;
                    default: c = '0;
                endcase
            end
            I: begin
                c.alusrc = 1'b1; c.regwrite = 1'b1;
                case (f3)
                    3'b000:  c.aluop = 4'd2;
                    3'b001:  c.aluop = 4'd12;
                    default: c = '0;
                endcase
            end
            L: begin c.memread = 1; c.memtoreg = 1; c.alusrc = 1; c.regwrite = 1; c.aluop = 4'd2; end
            S: begin c.memwrite = 1; c.alusrc = 1; c.aluop = 4'd2; end
            B: begin c.branch = 1; c.aluop = 4'd6; end
            default: c = '0;
        endcase
        return c;
    endfunction

    function automatic bit ref_hazard();
        return bus.id_valid && m_ex.memread && (m_ex.rd != 5'd0) &&
               (m_ex.rd == bus.id_rs1 || m_ex.rd == bus.id_rs2);
    endfunction

    task automatic drive(input bit v, input logic [6:0] op, input logic [2:0] f3,
                         input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input bit bt);
        bus.id_valid = v; bus.opcode = op; bus.funct3 = f3; bus.funct7 = f7;
        bus.id_rd = rd; bus.id_rs1 = rs1; bus.id_rs2 = rs2; bus.branch_taken = bt;
    endtask

    task automatic bubble();
        drive(0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 0);
    endtask

    // One clock: model predicts the next stage contents from the current inputs.
    task automatic tick();
        ctl_t nex, d;
        bit   bt, rst;
        bt  = bus.branch_taken;
        rst = reset;
        d   = ref_decode(bus.opcode, bus.funct3, bus.funct7);
        if (!bus.id_valid || bt || ref_hazard()) begin
            nex = '0;
        end else if (d == '0) begin
            nex = '0;
`ifdef CTRL_ILLEGAL_TRAP_EN
            nex.ill = 1'b1;
`else
            nex.rd = bus.id_rd;
`endif
        end else begin
            nex = d;
            nex.rd = bus.id_rd;
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_ex = '0; m_mem = '0; m_wb = '0;
        end else begin
            m_wb  = m_mem;
            m_mem = bt ? '0 : m_ex;
            m_ex  = nex;
        end
    endtask

    task automatic chk_stall(input string name);
        chk(name, 32'({bus.pc_write, bus.ifid_write}),
            (ref_hazard() && !bus.branch_taken) ? 32'd0 : 32'd3);
    endtask

    task automatic cmp_model(input string tag);
        chk({tag, ".ex"}, 32'({bus.ex_alusrc, bus.ex_aluop, bus.ex_rd}),
            32'({m_ex.alusrc, m_ex.aluop, m_ex.rd}));
        chk({tag, ".mem"}, 32'({bus.mem_branch, bus.mem_memread, bus.mem_memwrite,
                               bus.mem_regwrite, bus.mem_rd}),
            32'({m_mem.branch, m_mem.memread, m_mem.memwrite, m_mem.regwrite, m_mem.rd}));
        chk({tag, ".wb"}, 32'({bus.wb_memtoreg, bus.wb_regwrite, bus.wb_rd}),
            32'({m_wb.memtoreg, m_wb.regwrite, m_wb.rd}));
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'(m_ex.ill));
`endif
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".ex"}, 32'({bus.ex_alusrc, bus.ex_aluop, bus.ex_rd}), 32'd0);
        chk({tag, ".mem"}, 32'({bus.mem_branch, bus.mem_memread, bus.mem_memwrite,
                               bus.mem_regwrite, bus.mem_rd}), 32'd0);
        chk({tag, ".wb"}, 32'({bus.wb_memtoreg, bus.wb_regwrite, bus.wb_rd}), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk({tag, ".illegal"}, 32'(bus.illegal), 32'd0);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] ops [5];
        logic [4:0] rdv, exp_rd;
        ops = '{R, I, L, S, B};

        //        op  f3      f7    undef alusrc aluop br mr mw m2r rw
        vt[0]  = '{R, 3'b111, 7'h00, 0, 0, 4'h0, 0, 0, 0, 0, 1};
        vt[1]  = '{R, 3'b110, 7'h00, 0, 0, 4'h1, 0, 0, 0, 0, 1};
        vt[2]  = '{R, 3'b000, 7'h00, 0, 0, 4'h2, 0, 0, 0, 0, 1};
        vt[3]  = '{R, 3'b000, 7'h20, 0, 0, 4'h6, 0, 0, 0, 0, 1};
        vt[4]  = '{R, 3'b101, 7'h00, 1, 0, 4'h0, 0, 0, 0, 0, 0};
        vt[5]  = '{I, 3'b000, 7'h20, 0, 1, 4'h2, 0, 0, 0, 0, 1};
        vt[6]  = '{I, 3'b001, 7'h00, 0, 1, 4'hC, 0, 0, 0, 0, 1};
        vt[7]  = '{I, 3'b010, 7'h00, 1, 0, 4'h0, 0, 0, 0, 0, 0};
        vt[8]  = '{L, 3'b010, 7'h00, 0, 1, 4'h2, 0, 1, 0, 1, 1};
        vt[9]  = '{S, 3'b010, 7'h00, 0, 1, 4'h2, 0, 0, 1, 0, 0};
        vt[10] = '{B, 3'b000, 7'h00, 0, 0, 4'h6, 1, 0, 0, 0, 0};
        vt[11] = '{7'b1111111, 3'b000, 7'h00, 1, 0, 4'h0, 0, 0, 0, 0, 0};
        vt[12] = '{7'b0110111, 3'b000, 7'h00, 1, 0, 4'h0, 0, 0, 0, 0, 0};

        // Reset held two cycles, then add x3.
        bubble();
        reset = 1'b1;
        tick();
        tick();
        chk_all_zero("reset");
        reset = 1'b0;
        drive(1, R, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 0);
        #1 chk("add.pc_write", 32'({bus.pc_write, bus.ifid_write}), 32'd3);
        tick();
        chk("add.ex_aluop", 32'(bus.ex_aluop), 32'h2);
        chk("add.ex_rd", 32'(bus.ex_rd), 32'd3);
        bubble();
        tick();
        chk("add.mem_regwrite", 32'(bus.mem_regwrite), 32'd1);
        tick();
        chk("add.wb_rd", 32'(bus.wb_rd), 32'd3);
        chk("add.wb_regwrite", 32'(bus.wb_regwrite), 32'd1);

        // Decode table, each instruction followed through EX, MEM and WB.
        for (int i = 0; i < NV; i++) begin
            rdv = 5'(i + 1);
            exp_rd = rdv;
`ifdef CTRL_ILLEGAL_TRAP_EN
            if (vt[i].undef) exp_rd = 5'd0;
`endif
            drive(1, vt[i].op, vt[i].f3, vt[i].f7, rdv, 5'd0, 5'd0, 0);
            tick();
            chk($sformatf("vec%0d.ex", i), 32'({bus.ex_alusrc, bus.ex_aluop, bus.ex_rd}),
                32'({vt[i].alusrc, vt[i].aluop, exp_rd}));
`ifdef CTRL_ILLEGAL_TRAP_EN
            chk($sformatf("vec%0d.illegal", i), 32'(bus.illegal), 32'(vt[i].undef));
`endif
            bubble();
            tick();
            chk($sformatf("vec%0d.mem", i), 32'({bus.mem_branch, bus.mem_memread,
                bus.mem_memwrite, bus.mem_regwrite, bus.mem_rd}),
                32'({vt[i].branch, vt[i].memread, vt[i].memwrite, vt[i].regwrite, exp_rd}));
            tick();
            chk($sformatf("vec%0d.wb", i), 32'({bus.wb_memtoreg, bus.wb_regwrite, bus.wb_rd}),
                32'({vt[i].memtoreg, vt[i].regwrite, exp_rd}));
        end

        // lw x5 then add using x5: one stall cycle, bubble in EX, then add.
        drive(1, L, 3'b010, 7'h00, 5'd5, 5'd1, 5'd0, 0);
        tick();
        drive(1, R, 3'b000, 7'h00, 5'd6, 5'd5, 5'd0, 0);
        #1 chk("lu.stall", 32'({bus.pc_write, bus.ifid_write}), 32'd0);
        tick();
        chk("lu.ex_bubble", 32'({bus.ex_alusrc, bus.ex_aluop, bus.ex_rd}), 32'd0);
        chk("lu.mem_load", 32'({bus.mem_memread, bus.mem_rd}), 32'({1'b1, 5'd5}));
        chk("lu.resume", 32'({bus.pc_write, bus.ifid_write}), 32'd3);
        tick();
        chk("lu.ex_add", 32'({bus.ex_alusrc, bus.ex_aluop, bus.ex_rd}),
            32'({1'b0, 4'h2, 5'd6}));

        // lw x0 then consumer of x0: never a hazard.
        drive(1, L, 3'b010, 7'h00, 5'd0, 5'd1, 5'd0, 0);
        tick();
        drive(1, R, 3'b000, 7'h00, 5'd7, 5'd0, 5'd0, 0);
        #1 chk("x0.no_stall", 32'({bus.pc_write, bus.ifid_write}), 32'd3);
        tick();
        chk("x0.ex_add", 32'({bus.ex_aluop, bus.ex_rd}), 32'({4'h2, 5'd7}));

        // Branch taken together with a load-use hazard.
        drive(1, L, 3'b010, 7'h00, 5'd5, 5'd1, 5'd0, 0);
        tick();
        drive(1, R, 3'b000, 7'h00, 5'd8, 5'd5, 5'd0, 1);
        #1 chk("bt.no_stall", 32'({bus.pc_write, bus.ifid_write}), 32'd3);
        tick();
        chk("bt.ex_bubble", 32'({bus.ex_alusrc, bus.ex_aluop, bus.ex_rd}), 32'd0);
        chk("bt.mem_bubble", 32'({bus.mem_branch, bus.mem_memread, bus.mem_memwrite,
                                 bus.mem_regwrite, bus.mem_rd}), 32'd0);
        cmp_model("bt");

        // Undefined opcode 1111111.
        drive(1, 7'b1111111, 3'b000, 7'h00, 5'd9, 5'd0, 5'd0, 0);
        tick();
        chk("undef.ex_aluop", 32'(bus.ex_aluop), 32'd0);
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("undef.illegal", 32'(bus.illegal), 32'd1);
        chk("undef.ex_rd", 32'(bus.ex_rd), 32'd0);
`else
        chk("undef.ex_rd", 32'(bus.ex_rd), 32'd9);
`endif
        bubble();
        tick();
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("undef.illegal_once", 32'(bus.illegal), 32'd0);
`endif
        tick();
        chk("undef.wb_regwrite", 32'(bus.wb_regwrite), 32'd0);

        // Reset while a sub sits in MEM.
        drive(1, R, 3'b000, 7'h20, 5'd4, 5'd0, 5'd0, 0);
        tick();
        chk("sub.ex_aluop", 32'(bus.ex_aluop), 32'h6);
        bubble();
        tick();
        chk("sub.mem", 32'({bus.mem_regwrite, bus.mem_rd}), 32'({1'b1, 5'd4}));
        reset = 1'b1;
        tick();
        chk_all_zero("midreset");
        reset = 1'b0;
        #1 chk("midreset.pc_write", 32'({bus.pc_write, bus.ifid_write}), 32'd3);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 600; n++) begin
            int k;
            logic [6:0] op;
            reset = ($urandom_range(0, 49) == 0);
            k = $urandom_range(0, 5);
            if (k < 5) op = ops[k];
            else       op = 7'($urandom);
            drive($urandom_range(0, 7) != 0, op, 3'($urandom),
                  ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00,
                  5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                  5'($urandom_range(0, 3)), $urandom_range(0, 7) == 0);
            #1;
            if (!reset) chk_stall("rand.stall");
            tick();
            cmp_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
